// File: rtl/sd_spi_init_sequencer.sv
// SPI-mode SD card initialisation: slow SD clock, power-up dummy clocks, then
// CMD0 / CMD8 / CMD55+ACMD41 with R1 checking; reports ready card or error code.
module sd_spi_init_sequencer #(
    parameter int CLK_DIV      = 100,
    parameter int DUMMY_CLKS   = 80,
    parameter int RESP_TIMEOUT = 16,
    parameter int INIT_RETRIES = 1000
) (
    input  logic       CLOCK_50,
    input  logic       reset_n,
    input  logic       start,
    input  logic       sd_miso,
    output logic       sd_clk,
    output logic       sd_cs_n,
    output logic       sd_mosi,
    output logic       busy,
    output logic       done,
    output logic       error,
    output logic [2:0] err_code,
    output logic [7:0] last_r1,
    output logic       card_v2
);

    typedef enum logic [3:0] {
        S_IDLE, S_POWERUP, S_SEND, S_WAIT_R1, S_CHECK, S_TAIL, S_GAP, S_DONE, S_ERROR
    } state_t;

    localparam logic [1:0] C_CMD0   = 2'd0;
    localparam logic [1:0] C_CMD8   = 2'd1;
    localparam logic [1:0] C_CMD55  = 2'd2;
    localparam logic [1:0] C_ACMD41 = 2'd3;

    state_t      state, state_n;
    logic [1:0]  cmd, cmd_n;
    logic [15:0] div_cnt, cnt, retry_cnt;
    logic [7:0]  byte_cnt;
    logic [6:0]  rx;
    logic [11:0] tail;
    logic        have_tail;
    logic        rise_tick, fall_tick, accept, term_n, active_n, r1_found;
    logic [7:0]  rx_byte;
    logic [47:0] frame;
    logic        err_set, v2_wr, v2_val, retry_inc;
    logic [2:0]  err_val;

    // Last byte carries crc7 plus the stop bit.
    function automatic logic [47:0] cmd_frame(input logic [1:0] c, input logic v2);
        logic [47:0] f;
        case (c)
            C_CMD0:   f = {2'b01, 6'd0,  32'h0000_0000, 8'h95};
            C_CMD8:   f = {2'b01, 6'd8,  32'h0000_01AA, 8'h87};
            C_CMD55:  f = {2'b01, 6'd55, 32'h0000_0000, 8'h65};
            C_ACMD41: f = v2 ? {2'b01, 6'd41, 32'h4000_0000, 8'h77}
                             : {2'b01, 6'd41, 32'h0000_0000, 8'hE5};
            default:  f = {48{1'b1}};
        endcase
        return f;
    endfunction

    assign rise_tick = busy && (div_cnt == 16'(CLK_DIV - 1)) && !sd_clk;
    assign fall_tick = busy && (div_cnt == 16'(CLK_DIV - 1)) && sd_clk;
    assign rx_byte   = {rx, sd_miso};
    assign r1_found  = (state == S_WAIT_R1) && rise_tick && (cnt[2:0] == 3'd7) && !rx_byte[7];
    assign accept    = start && (state == S_IDLE || state == S_DONE || state == S_ERROR);
    assign term_n    = (state_n == S_IDLE || state_n == S_DONE || state_n == S_ERROR);
    assign active_n  = (state_n == S_SEND || state_n == S_WAIT_R1 || state_n == S_CHECK || state_n == S_TAIL);
    assign frame     = cmd_frame(cmd, card_v2);

    // Next-state and command-decision logic.
    always_comb begin
        state_n   = state;
        cmd_n     = cmd;
        err_set   = 1'b0;
        err_val   = 3'd0;
        v2_wr     = 1'b0;
        v2_val    = 1'b0;
        retry_inc = 1'b0;
        case (state)
            S_IDLE, S_DONE, S_ERROR: begin
                if (start) state_n = S_POWERUP;
                else       state_n = state;
            end
            S_POWERUP: begin
                if (rise_tick && cnt == 16'(DUMMY_CLKS - 1)) begin
                    state_n = S_SEND;
                    cmd_n   = C_CMD0;
                end else begin
                    state_n = S_POWERUP;
                end
            end
            S_SEND: begin
                if (rise_tick && cnt == 16'd47) state_n = S_WAIT_R1;
                else                            state_n = S_SEND;
            end
            S_WAIT_R1: begin
                if (r1_found) begin
                    state_n = S_CHECK;
                end else if (rise_tick && cnt[2:0] == 3'd7 && byte_cnt == 8'(RESP_TIMEOUT - 1)) begin
                    state_n = S_ERROR;
                    err_set = 1'b1;
                    err_val = 3'd5;
                end else begin
                    state_n = S_WAIT_R1;
                end
            end
            S_TAIL: begin
                if (rise_tick && cnt == 16'd31) state_n = S_CHECK;
                else                            state_n = S_TAIL;
            end
            S_GAP: begin
                if (rise_tick && cnt == 16'd7) state_n = S_SEND;
                else                           state_n = S_GAP;
            end
            S_CHECK: begin
                case (cmd)
                    C_CMD0: begin
                        if (last_r1 == 8'h01) begin
                            state_n = S_GAP; cmd_n = C_CMD8;
                        end else begin
                            state_n = S_ERROR; err_set = 1'b1; err_val = 3'd1;
                        end
                    end
                    C_CMD8: begin
                        if (last_r1 == 8'h01 && !have_tail) begin
                            state_n = S_TAIL;
                        end else if (last_r1 == 8'h01 && tail == 12'h1AA) begin
                            state_n = S_GAP; cmd_n = C_CMD55; v2_wr = 1'b1; v2_val = 1'b1;
                        end else if (last_r1 != 8'h01 && last_r1[2]) begin
                            state_n = S_GAP; cmd_n = C_CMD55; v2_wr = 1'b1; v2_val = 1'b0;
                        end else begin
                            state_n = S_ERROR; err_set = 1'b1; err_val = 3'd2;
                        end
                    end
                    C_CMD55: begin
                        if (last_r1 == 8'h00 || last_r1 == 8'h01) begin
                            state_n = S_GAP; cmd_n = C_ACMD41;
                        end else begin
                            state_n = S_ERROR; err_set = 1'b1; err_val = 3'd3;
                        end
                    end
                    C_ACMD41: begin
                        if (last_r1 == 8'h00) begin
                            state_n = S_DONE;
                        end else if (last_r1 == 8'h01 && (retry_cnt + 16'd1) != 16'(INIT_RETRIES)) begin
                            state_n = S_GAP; cmd_n = C_CMD55; retry_inc = 1'b1;
                        end else begin
                            state_n = S_ERROR; err_set = 1'b1; err_val = 3'd4; retry_inc = 1'b1;
                        end
                    end
                    default: begin
                        state_n = S_ERROR; err_set = 1'b1; err_val = 3'd1;
                    end
                endcase
            end
            default: state_n = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge CLOCK_50) begin
        if (!reset_n) begin
            state <= S_IDLE;
            cmd   <= C_CMD0;
        end else begin
            state <= state_n;
            cmd   <= cmd_n;
        end
    end

    // SD clock divider and pin drivers; MOSI only moves on falling ticks.
    always_ff @(posedge CLOCK_50) begin
        if (!reset_n) begin
            div_cnt <= 16'd0;
            sd_clk  <= 1'b0;
            sd_cs_n <= 1'b1;
            sd_mosi <= 1'b1;
            busy    <= 1'b0;
        end else begin
            busy    <= !term_n;
            sd_cs_n <= !active_n;
            if (term_n || !busy) begin
                div_cnt <= 16'd0;
                sd_clk  <= 1'b0;
            end else if (div_cnt == 16'(CLK_DIV - 1)) begin
                div_cnt <= 16'd0;
                sd_clk  <= !sd_clk;
            end else begin
                div_cnt <= div_cnt + 16'd1;
            end
            if (accept || term_n) sd_mosi <= 1'b1;
            else if (fall_tick)   sd_mosi <= (state == S_SEND) ? frame[6'd47 - cnt[5:0]] : 1'b1;
            else                  sd_mosi <= sd_mosi;
        end
    end

    // Bit/byte counters, receive shifters and status outputs.
    always_ff @(posedge CLOCK_50) begin
        if (!reset_n) begin
            cnt       <= 16'd0;
            byte_cnt  <= 8'd0;
            retry_cnt <= 16'd0;
            rx        <= 7'h7F;
            tail      <= 12'd0;
            have_tail <= 1'b0;
            last_r1   <= 8'hFF;
            done      <= 1'b0;
            error     <= 1'b0;
            err_code  <= 3'd0;
            card_v2   <= 1'b0;
        end else begin
            if (state_n != state) cnt <= 16'd0;
            else if (rise_tick)   cnt <= cnt + 16'd1;
            else                  cnt <= cnt;
            if (state_n != state)                                          byte_cnt <= 8'd0;
            else if (state == S_WAIT_R1 && rise_tick && cnt[2:0] == 3'd7)  byte_cnt <= byte_cnt + 8'd1;
            else                                                           byte_cnt <= byte_cnt;
            if (rise_tick) rx <= rx_byte[6:0];
            else           rx <= rx;
            if (rise_tick && state == S_TAIL) tail <= {tail[10:0], sd_miso};
            else                              tail <= tail;
            if (state == S_SEND)      have_tail <= 1'b0;
            else if (state == S_TAIL) have_tail <= 1'b1;
            else                      have_tail <= have_tail;
            if (r1_found) last_r1 <= rx_byte;
            else          last_r1 <= last_r1;
            if (accept) begin
                done      <= 1'b0;
                error     <= 1'b0;
                err_code  <= 3'd0;
                card_v2   <= 1'b0;
                retry_cnt <= 16'd0;
            end else begin
                if (err_set) begin
                    error    <= 1'b1;
                    err_code <= err_val;
                end else begin
                    error    <= error;
                    err_code <= err_code;
                end
                done      <= done || (state_n == S_DONE && state != S_DONE);
                card_v2   <= v2_wr ? v2_val : card_v2;
                retry_cnt <= retry_inc ? retry_cnt + 16'd1 : retry_cnt;
            end
        end
    end

endmodule

// File: tb/tb_sd_spi_init_sequencer.sv
// Scoreboard bench: a behavioural SPI-mode SD card checks each command frame
// against an expected queue, and final status is compared per scenario.
module tb_sd_spi_init_sequencer;

    localparam logic [47:0] F_CMD0   = 48'h400000000095;
    localparam logic [47:0] F_CMD8   = 48'h48000001AA87;
    localparam logic [47:0] F_CMD55  = 48'h770000000065;
    localparam logic [47:0] F_A41_V2 = 48'h694000000077;
    localparam logic [47:0] F_A41_V1 = 48'h6900000000E5;

    logic       CLOCK_50 = 1'b0;
    logic       reset_n, start;
    logic       sd_miso = 1'b1;
    logic       sd_clk, sd_cs_n, sd_mosi, busy, done, error, card_v2;
    logic [2:0] err_code;
    logic [7:0] last_r1;

    int checks   = 0;
    int failures = 0;

    logic [47:0] exp_frames[$];
    logic [13:0] exp_status[$];

    bit          cfg_mute, cfg_ab;
    logic [7:0]  cfg_r0, cfg_r8;
    logic [31:0] cfg_tail;
    int          cfg_bn;

    bit          resp_q[$];
    logic [47:0] rx_sh;
    int          rx_n = 0, acmd_cnt = 0, pre_clks = 0, frames_got = 0;
    bit          seen_frame = 1'b0;
    logic        prev_clk = 1'b0, prev_cs = 1'b1;

    sd_spi_init_sequencer #(
        .CLK_DIV(4), .DUMMY_CLKS(80), .RESP_TIMEOUT(16), .INIT_RETRIES(3)
    ) dut (
        .CLOCK_50(CLOCK_50), .reset_n(reset_n), .start(start), .sd_miso(sd_miso),
        .sd_clk(sd_clk), .sd_cs_n(sd_cs_n), .sd_mosi(sd_mosi), .busy(busy),
        .done(done), .error(error), .err_code(err_code), .last_r1(last_r1),
        .card_v2(card_v2)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [13:0] st(input logic d, input logic e, input logic [2:0] c,
                                       input logic [7:0] r, input logic v);
        return {d, e, c, r, v};
    endfunction

    task automatic push_r1(input logic [7:0] r);
        for (int i = 0; i < 8; i++) resp_q.push_back(1'b1);
        for (int i = 7; i >= 0; i--) resp_q.push_back(r[i]);
    endtask

    task automatic take_frame(input logic [47:0] f);
        frames_got++;
        if (exp_frames.size() > 0) check_val("frame", f, exp_frames.pop_front());
        else                       check_val("frame_extra", f, 48'h0);
        if (!cfg_mute) begin
            case (f[45:40])
                6'd0:  push_r1(cfg_r0);
                6'd8: begin
                    push_r1(cfg_r8);
                    if (cfg_r8 == 8'h01)
                        for (int i = 31; i >= 0; i--) resp_q.push_back(cfg_tail[i]);
                end
                6'd55: push_r1(8'h01);
                6'd41: begin
                    acmd_cnt++;
                    push_r1((cfg_ab || acmd_cnt <= cfg_bn) ? 8'h01 : 8'h00);
                end
                default: push_r1(8'h04);
            endcase
        end
    endtask

    // Card model: samples MOSI on sd_clk rise, drives MISO after sd_clk fall.
    always @(negedge CLOCK_50) begin
        if (start && !busy) begin
            rx_n = 0; acmd_cnt = 0; pre_clks = 0; seen_frame = 1'b0;
            resp_q.delete();
        end
        if (sd_clk && !prev_clk) begin
            if (prev_cs) begin
                rx_n = 0;
                if (!seen_frame) pre_clks++;
            end else if (rx_n > 0 || !sd_mosi) begin
                rx_sh = {rx_sh[46:0], sd_mosi};
                rx_n++;
                if (rx_n == 48) begin
                    rx_n = 0;
                    seen_frame = 1'b1;
                    take_frame(rx_sh);
                end
            end
        end else if (!sd_clk && prev_clk) begin
            if (!sd_cs_n && resp_q.size() > 0) sd_miso = resp_q.pop_front();
            else                               sd_miso = 1'b1;
        end
        if (sd_cs_n) resp_q.delete();
        prev_clk = sd_clk;
        prev_cs  = sd_cs_n;
    end

    task automatic begin_scn(input string tag, input bit mute, input logic [7:0] r0,
                             input logic [7:0] r8, input logic [31:0] tl, input int bn,
                             input bit ab, input logic [13:0] exp_st);
        cfg_mute = mute; cfg_r0 = r0; cfg_r8 = r8; cfg_tail = tl; cfg_bn = bn; cfg_ab = ab;
        exp_status.push_back(exp_st);
        @(posedge CLOCK_50); #1 start = 1'b1;
        @(posedge CLOCK_50); #1 start = 1'b0;
        check_val({tag, "_busy"}, {busy, done, error}, 3'b100);
    endtask

    task automatic end_scn(input string tag, input bit chk_dummy, input int exp_acmd);
        bit fin;
        fin = 1'b0;
        for (int i = 0; i < 20000; i++) begin
            @(posedge CLOCK_50); #1;
            if (done || error) begin
                fin = 1'b1;
                break;
            end
        end
        check_val({tag, "_finish"}, fin, 1);
        if (exp_status.size() > 0)
            check_val({tag, "_status"}, {done, error, err_code, last_r1, card_v2}, exp_status.pop_front());
        check_val({tag, "_idle_pins"}, {busy, sd_cs_n, sd_clk}, 3'b010);
        check_val({tag, "_frames_left"}, exp_frames.size(), 0);
        if (chk_dummy) check_val({tag, "_dummy"}, pre_clks, 80);
        check_val({tag, "_acmd41"}, acmd_cnt, exp_acmd);
    endtask

    task automatic wait_cs(input logic v);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 5000; i++) begin
            @(posedge CLOCK_50); #1;
            if (sd_cs_n == v) begin
                ok = 1'b1;
                break;
            end
        end
        check_val("wait_cs", ok, 1);
    endtask

    task automatic push_pairs(input int n, input logic [47:0] a41);
        for (int i = 0; i < n; i++) begin
            exp_frames.push_back(F_CMD55);
            exp_frames.push_back(a41);
        end
    endtask

    initial begin
        reset_n = 1'b0;
        start   = 1'b0;
        repeat (3) @(posedge CLOCK_50);
        #1 check_val("reset_state", {sd_clk, sd_cs_n, sd_mosi, busy, done, error, err_code, last_r1, card_v2},
                     17'b0_1_1_0_0_0_000_11111111_0);
        reset_n = 1'b1;

        // MISO stuck high: CMD0 then 16 padding bytes -> timeout.
        exp_frames.push_back(F_CMD0);
        begin_scn("mute", 1'b1, 8'h01, 8'h01, 32'h1AA, 0, 1'b0, st(1'b0, 1'b1, 3'd5, 8'hFF, 1'b0));
        end_scn("mute", 1'b1, 0);

        // SDv2 card, ACMD41 busy twice then ready.
        exp_frames.push_back(F_CMD0);
        exp_frames.push_back(F_CMD8);
        push_pairs(3, F_A41_V2);
        begin_scn("v2", 1'b0, 8'h01, 8'h01, 32'h0000_01AA, 2, 1'b0, st(1'b1, 1'b0, 3'd0, 8'h00, 1'b1));
        end_scn("v2", 1'b1, 3);

        // SDv1 card: CMD8 illegal, ACMD41 with zero argument.
        exp_frames.push_back(F_CMD0);
        exp_frames.push_back(F_CMD8);
        push_pairs(1, F_A41_V1);
        begin_scn("v1", 1'b0, 8'h01, 8'h05, 32'h0, 0, 1'b0, st(1'b1, 1'b0, 3'd0, 8'h00, 1'b0));
        end_scn("v1", 1'b1, 1);

        // ACMD41 never ready: retries exhausted after three attempts.
        exp_frames.push_back(F_CMD0);
        exp_frames.push_back(F_CMD8);
        push_pairs(3, F_A41_V2);
        begin_scn("retry", 1'b0, 8'h01, 8'h01, 32'h0000_01AA, 0, 1'b1, st(1'b0, 1'b1, 3'd4, 8'h01, 1'b1));
        end_scn("retry", 1'b1, 3);

        // Bad CMD8 echo pattern.
        exp_frames.push_back(F_CMD0);
        exp_frames.push_back(F_CMD8);
        begin_scn("tail", 1'b0, 8'h01, 8'h01, 32'h0000_01AB, 0, 1'b0, st(1'b0, 1'b1, 3'd2, 8'h01, 1'b0));
        end_scn("tail", 1'b1, 0);

        // CMD0 not answered with idle.
        exp_frames.push_back(F_CMD0);
        begin_scn("cmd0", 1'b0, 8'h00, 8'h01, 32'h1AA, 0, 1'b0, st(1'b0, 1'b1, 3'd1, 8'h00, 1'b0));
        end_scn("cmd0", 1'b1, 0);

        // Reset in the middle of the CMD8 frame, together with a start pulse.
        exp_frames.push_back(F_CMD0);
        begin_scn("rst", 1'b0, 8'h01, 8'h01, 32'h1AA, 0, 1'b0, st(1'b1, 1'b0, 3'd0, 8'h00, 1'b1));
        wait_cs(1'b0);
        wait_cs(1'b1);
        wait_cs(1'b0);
        repeat (100) @(posedge CLOCK_50);
        #1 reset_n = 1'b0;
        start = 1'b1;
        @(posedge CLOCK_50);
        #1 check_val("midrst_state", {sd_clk, sd_cs_n, sd_mosi, busy, done, error, err_code, last_r1, card_v2},
                     17'b0_1_1_0_0_0_000_11111111_0);
        reset_n = 1'b1;
        start   = 1'b0;
        @(posedge CLOCK_50);
        #1 check_val("midrst_stay_idle", {busy, sd_cs_n}, 2'b01);
        check_val("midrst_frames_left", exp_frames.size(), 0);
        exp_status.delete();

        // Full rerun with a start pulse injected while busy (must be ignored).
        exp_frames.push_back(F_CMD0);
        exp_frames.push_back(F_CMD8);
        push_pairs(3, F_A41_V2);
        begin_scn("rerun", 1'b0, 8'h01, 8'h01, 32'h0000_01AA, 2, 1'b0, st(1'b1, 1'b0, 3'd0, 8'h00, 1'b1));
        repeat (2000) @(posedge CLOCK_50);
        #1 start = 1'b1;
        @(posedge CLOCK_50);
        #1 start = 1'b0;
        check_val("rerun_busy_kept", busy, 1);
        end_scn("rerun", 1'b1, 3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
